seq_adder_accum: RTL and testbench

- Multi-cycle counterpart to the combinational adder tree.
- Accepts one packed vector of LENGTH signed addends through a valid/ready handshake and latches it.
- Adds one element per clock into a sign-extended accumulator, then presents the sum on a valid/ready output port.
- Used where area matters more than latency, and as a bit-exact golden model for adder-tree results.

---
 rtl/seq_adder_accum.sv | 101 ++++++++++
 tb/tb_seq_adder_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_adder_accum.sv
// Multi-cycle signed summation: latches a vector of LENGTH addends, adds one per clock
// into a sign-extended accumulator, and hands the sum out on a valid/ready port.
//
// state | meaning
// ------+-----------------------------------------------------
// IDLE  | waiting for a vector, in_ready high
// ACCUM | adding latched element[index] once per clock
// DONE  | out_sum valid, held until out_ready
module seq_adder_accum #(
  parameter int DATA_WIDTH = 32,
  parameter int LENGTH     = 8,
  parameter int OUT_WIDTH  = DATA_WIDTH + $clog2(LENGTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_addends,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_sum,
  output logic                         out_busy
);

  localparam int IDX_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                         state, state_next;
  logic [LENGTH*DATA_WIDTH-1:0]   vec_q;
  logic signed [OUT_WIDTH-1:0]    acc_q;
  logic signed [OUT_WIDTH-1:0]    acc_sum;
  logic [OUT_WIDTH-1:0]           sum_q;
  logic [IDX_W-1:0]               idx_q;
  logic signed [DATA_WIDTH-1:0]   elem [LENGTH];
  logic                           last;

  for (genvar g = 0; g < LENGTH; g++) begin : g_elem
    assign elem[g] = vec_q[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Size cast of a signed operand sign-extends to the accumulator width.
  assign acc_sum = acc_q + OUT_WIDTH'(elem[idx_q]);
  assign last    = (idx_q == IDX_W'(LENGTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_busy   = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        out_busy = 1'b0;
        if (in_valid) state_next = ACCUM;
      end
      ACCUM: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q <= in_addends;
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ACCUM: begin
          acc_q <= acc_sum;
          // index parks on the last element instead of wrapping
          if (last) sum_q <= acc_sum;
          else      idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_sum = sum_q;

endmodule

// File: tb/tb_seq_adder_accum.sv
// Directed bench for seq_adder_accum with a queue scoreboard: expected sums are pushed
// on each accepted vector and compared when a result is consumed.
module tb_seq_adder_accum;

  localparam int DW = 32;
  localparam int L  = 8;
  localparam int OW = 35;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [L*DW-1:0]   in_addends = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OW-1:0]     out_sum;
  logic              out_busy;

  seq_adder_accum #(.DATA_WIDTH(DW), .LENGTH(L), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addends(in_addends),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_busy(out_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [OW-1:0] sb[$];
  int acc_cyc = 0, cons_cyc = 0, prev_cons_cyc = 0;
  int nacc = 0, ncons = 0;

  function automatic logic [OW-1:0] ref_sum(input logic [L*DW-1:0] v);
    longint s = 0;
    for (int i = 0; i < L; i++) s += longint'($signed(v[i*DW +: DW]));
    return s[OW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Evaluate the handshakes visible now, then advance to the next falling edge.
  task automatic step();
    if (in_valid && in_ready) begin
      sb.push_back(ref_sum(in_addends));
      acc_cyc = cyc;
      nacc++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $error("FAIL unexpected_out: observed=%0h expected=none", out_sum);
      end else begin
        check("sb_sum", 64'(out_sum), 64'(sb.pop_front()));
      end
      prev_cons_cyc = cons_cyc;
      cons_cyc = cyc;
      ncons++;
    end
    @(negedge clk);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!out_valid && n < max) begin step(); n++; end
    check("wait_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic rand_vec(output logic [L*DW-1:0] v);
    for (int i = 0; i < L; i++) v[i*DW +: DW] = $urandom();
  endtask

  initial begin
    logic [L*DW-1:0] v1, v2;
    logic [OW-1:0]   exp_bp;
    int first_acc, n, nv, c0;

    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_busy", 64'(out_busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;

    // reference vector, element 7 at MSB
    in_addends = {32'sd123, -32'sd387, -32'sd1468, 32'sd1189,
                  32'sd4396, -32'sd231, 32'sd666, 32'sd999};
    in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_valid(20);
    check("latency", 64'(cyc - acc_cyc - 1), 64'd8);
    check("plan_sum", 64'(out_sum), 64'h14A7);
    check("done_busy", 64'(out_busy), 64'd1);
    check("done_in_ready", 64'(in_ready), 64'd0);
    step();
    check("after_valid", 64'(out_valid), 64'd0);
    check("after_in_ready", 64'(in_ready), 64'd1);
    check("after_held_sum", 64'(out_sum), 64'h14A7);
    check("after_busy", 64'(out_busy), 64'd0);

    in_addends = {L{32'h80000000}};
    in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_valid(20);
    check("min_sum", 64'(out_sum), 64'h400000000);
    step();

    in_addends = {L{32'h7FFFFFFF}};
    in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_valid(20);
    check("max_sum", 64'(out_sum), 64'h3FFFFFFF8);
    step();

    // backpressure
    out_ready = 1'b0;
    rand_vec(v1); in_addends = v1; exp_bp = ref_sum(v1);
    in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_valid(20);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_sum", 64'(out_sum), 64'(exp_bp));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_busy", 64'(out_busy), 64'd1);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);

    // input changes while busy are ignored
    in_addends = '1;
    in_valid = 1'b1; step();
    first_acc = acc_cyc;
    n = 0;
    while (!in_ready && n < 30) begin
      rand_vec(v1); in_addends = v1;
      step(); n++;
    end
    check("chg_idle_reached", 64'(in_ready), 64'd1);
    check("chg_ones_sum", 64'(out_sum), 64'h7FFFFFFF8);
    step();
    in_valid = 1'b0;
    check("chg_reaccept_gap", 64'(acc_cyc - first_acc), 64'd10);
    wait_valid(20);
    step();

    // asynchronous reset in the middle of accumulation
    rand_vec(v1); in_addends = v1;
    in_valid = 1'b1; step(); in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(out_sum), 64'd0);
    check("mid_rst_busy", 64'(out_busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    nv = 0;
    repeat (12) begin nv += int'(out_valid); @(negedge clk); end
    check("mid_rst_no_pulse", 64'(nv), 64'd0);
    in_addends = {L{32'd1}};
    in_valid = 1'b1; step(); in_valid = 1'b0;
    wait_valid(20);
    check("post_rst_sum", 64'(out_sum), 64'd8);
    step();

    // back-to-back with in_valid held high
    rand_vec(v1); rand_vec(v2);
    c0 = ncons;
    first_acc = nacc;
    in_addends = v1; in_valid = 1'b1; step();
    in_addends = v2;
    n = 0;
    while (ncons < c0 + 2 && n < 40) begin
      if (nacc >= first_acc + 2) in_valid = 1'b0;
      step(); n++;
    end
    in_valid = 1'b0;
    check("b2b_results", 64'(ncons - c0), 64'd2);
    check("b2b_spacing", 64'(cons_cyc - prev_cons_cyc), 64'd10);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
